// File: rtl/issue_sequencer.sv
// -----------------------------------------------------------------------------
// issue_sequencer
// Single-issue front-end sequencer for the Nebula RV32 core. Holds a two-stage
// pipeline between fetch and execute:
//   D stage : instruction presented to the registered instruction_decoder
//   I stage : instruction decoded by the decoder and awaiting issue
// It stalls FENCE until all outstanding memory operations drain, and it limits
// in-flight memory operations to MEM_MAX. On an illegal instruction it freezes
// the pipeline and holds a trap until flush.
//
// Ports
//   clk, n_rst              : clock, asynchronous active-low reset
//   f_valid/f_inst/f_pc     : fetch offer;  f_ready : D stage can accept
//   dec_instruction         : D-stage instruction to the decoder
//   dec_n_irdy              : active-low "D stage holds a valid instruction"
//   dec_n_stall             : active-low decoder hold
//   dec_inst_type/dec_fence/dec_n_bad_inst : decoder results for the I stage
//   ex_ready                : execute accepts this cycle
//   issue_valid/issue_pc    : I-stage instruction offered to execute
//   mem_done                : one memory operation completed
//   flush                   : redirect, empties the pipeline
//   trap/trap_pc            : illegal-instruction trap pending and its PC
//   fence_busy              : waiting for memory operations before a FENCE
//   mem_cnt                 : outstanding memory operations
// -----------------------------------------------------------------------------
module issue_sequencer #(
   parameter int unsigned MEM_MAX = 7
) (
   input  logic                           clk,
   input  logic                           n_rst,
   input  logic                           f_valid,
   input  logic [31:0]                    f_inst,
   input  logic [31:0]                    f_pc,
   output logic                           f_ready,
   output logic [31:0]                    dec_instruction,
   output logic                           dec_n_irdy,
   output logic                           dec_n_stall,
   input  logic [3:0]                     dec_inst_type,
   input  logic                           dec_fence,
   input  logic                           dec_n_bad_inst,
   input  logic                           ex_ready,
   output logic                           issue_valid,
   output logic [31:0]                    issue_pc,
   input  logic                           mem_done,
   input  logic                           flush,
   output logic                           trap,
   output logic [31:0]                    trap_pc,
   output logic                           fence_busy,
   output logic [$clog2(MEM_MAX+1)-1:0]   mem_cnt
);

   localparam int unsigned CW = $clog2(MEM_MAX + 1);
   localparam int unsigned XW = 32;

   typedef enum logic [1:0] {
      S_RUN         = 2'd0,
      S_FENCE_DRAIN = 2'd1,
      S_TRAP        = 2'd2
   } state_e;

   state_e          state_q,    state_d;
   logic            ir_valid_q, ir_valid_d;
   logic [XW-1:0]   ir_inst_q,  ir_inst_d;
   logic [XW-1:0]   ir_pc_q,    ir_pc_d;
   logic            i_valid_q,  i_valid_d;
   logic [XW-1:0]   i_pc_q,     i_pc_d;
   logic [XW-1:0]   trap_pc_q,  trap_pc_d;
   logic [CW-1:0]   mem_cnt_q,  mem_cnt_d;

   logic is_mem;
   logic cnt_zero;
   logic cnt_full;
   logic issue_ok;
   logic fire;
   logic advance;
   logic f_ready_c;
   logic accept;
   logic cnt_inc;
   logic cnt_dec;

   // Only the memory bit of the decoder type vector matters here.
   logic unused_inst_type;
   assign unused_inst_type = ^dec_inst_type[3:1];

   // Issue gating and pipeline handshake.
   always_comb begin
      is_mem    = dec_inst_type[0];
      cnt_zero  = (mem_cnt_q == '0);
      cnt_full  = (mem_cnt_q == CW'(MEM_MAX));
      // A FENCE waits for memory to drain; a load/store waits for a free slot.
      issue_ok  = i_valid_q
                & (state_q == S_RUN)
                & dec_n_bad_inst
                & ~(dec_fence & ~cnt_zero)
                & ~(is_mem & cnt_full);
      fire      = issue_ok & ex_ready;
      advance   = (state_q != S_TRAP) & (~i_valid_q | fire);
      f_ready_c = ~flush & (~ir_valid_q | advance);
      accept    = f_valid & f_ready_c;
      cnt_inc   = fire & is_mem;
      // A completion with nothing outstanding is ignored.
      cnt_dec   = mem_done & ~cnt_zero;
   end

   // Next-state logic for the pipeline registers, counter and FSM.
   always_comb begin
      state_d    = state_q;
      ir_valid_d = ir_valid_q;
      ir_inst_d  = ir_inst_q;
      ir_pc_d    = ir_pc_q;
      i_valid_d  = i_valid_q;
      i_pc_d     = i_pc_q;
      trap_pc_d  = trap_pc_q;
      mem_cnt_d  = mem_cnt_q;

      // Counter keeps running through flush: issued operations still complete.
      unique case ({cnt_inc, cnt_dec})
         2'b10:   mem_cnt_d = mem_cnt_q + CW'(1);
         2'b01:   mem_cnt_d = mem_cnt_q - CW'(1);
         default: mem_cnt_d = mem_cnt_q;
      endcase

      if (flush) begin
         ir_valid_d = 1'b0;
         i_valid_d  = 1'b0;
         state_d    = S_RUN;
      end else begin
         if (advance) begin
            i_valid_d = ir_valid_q;
            i_pc_d    = ir_pc_q;
         end

         // D refills from fetch whenever it is free or moving on.
         if (accept) begin
            ir_valid_d = 1'b1;
            ir_inst_d  = f_inst;
            ir_pc_d    = f_pc;
         end else if (advance) begin
            ir_valid_d = 1'b0;
         end

         unique case (state_q)
            S_RUN: begin
               if (i_valid_q & ~dec_n_bad_inst) begin
                  state_d   = S_TRAP;
                  trap_pc_d = i_pc_q;
               end else if (i_valid_q & dec_fence & ~cnt_zero) begin
                  state_d = S_FENCE_DRAIN;
               end
            end
            S_FENCE_DRAIN: begin
               // Leave on the edge where the count reaches zero, so the fence
               // issues in the very next cycle.
               if (mem_cnt_d == '0) state_d = S_RUN;
            end
            S_TRAP: begin
               state_d = S_TRAP;
            end
            default: begin
               state_d = S_RUN;
            end
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_RUN;
         ir_valid_q <= 1'b0;
         ir_inst_q  <= '0;
         ir_pc_q    <= '0;
         i_valid_q  <= 1'b0;
         i_pc_q     <= '0;
         trap_pc_q  <= '0;
         mem_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         ir_valid_q <= ir_valid_d;
         ir_inst_q  <= ir_inst_d;
         ir_pc_q    <= ir_pc_d;
         i_valid_q  <= i_valid_d;
         i_pc_q     <= i_pc_d;
         trap_pc_q  <= trap_pc_d;
         mem_cnt_q  <= mem_cnt_d;
      end
   end

   // Output mapping.
   assign f_ready         = f_ready_c;
   assign dec_instruction = ir_inst_q;
   assign dec_n_irdy      = ~ir_valid_q;
   assign dec_n_stall     = advance;
   assign issue_valid     = issue_ok;
   assign issue_pc        = i_pc_q;
   assign trap            = (state_q == S_TRAP);
   assign trap_pc         = trap_pc_q;
   assign fence_busy      = (state_q == S_FENCE_DRAIN);
   assign mem_cnt         = mem_cnt_q;

endmodule

// File: tb/tb_issue_sequencer.sv
// -----------------------------------------------------------------------------
// tb_issue_sequencer
// Bench for issue_sequencer: a behavioural registered decoder, a PC scoreboard
// (push on fetch accept, pop on issue), a per-cycle vector table for streaming
// and backpressure, and hand sequences for fence drain, counter saturation,
// trap/flush and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_issue_sequencer;

   localparam logic [31:0] ADDI  = 32'h0000_0013;
   localparam logic [31:0] LW    = 32'h0000_2003;
   localparam logic [31:0] FENCE = 32'h0FF0_000F;
   localparam logic [31:0] BAD   = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        f_valid;
   logic [31:0] f_inst;
   logic [31:0] f_pc;
   logic        f_ready;
   logic [31:0] dec_instruction;
   logic        dec_n_irdy;
   logic        dec_n_stall;
   logic [3:0]  dec_inst_type;
   logic        dec_fence;
   logic        dec_n_bad_inst;
   logic        ex_ready;
   logic        issue_valid;
   logic [31:0] issue_pc;
   logic        mem_done;
   logic        flush;
   logic        trap;
   logic [31:0] trap_pc;
   logic        fence_busy;
   logic [2:0]  mem_cnt;

   int checks   = 0;
   int failures = 0;
   logic [31:0] sb[$];

   issue_sequencer #(.MEM_MAX(7)) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .f_valid        (f_valid),
      .f_inst         (f_inst),
      .f_pc           (f_pc),
      .f_ready        (f_ready),
      .dec_instruction(dec_instruction),
      .dec_n_irdy     (dec_n_irdy),
      .dec_n_stall    (dec_n_stall),
      .dec_inst_type  (dec_inst_type),
      .dec_fence      (dec_fence),
      .dec_n_bad_inst (dec_n_bad_inst),
      .ex_ready       (ex_ready),
      .issue_valid    (issue_valid),
      .issue_pc       (issue_pc),
      .mem_done       (mem_done),
      .flush          (flush),
      .trap           (trap),
      .trap_pc        (trap_pc),
      .fence_busy     (fence_busy),
      .mem_cnt        (mem_cnt)
   );

   always #5 clk = ~clk;

   // Decoder model: {n_bad, fence, alu, fpu, fpu_sd, mem}
   function automatic logic [5:0] decode(input logic [31:0] inst);
      logic [6:0] op;
      op = inst[6:0];
      case (op)
         7'h13:   decode = 6'b10_1000;
         7'h03:   decode = 6'b10_0001;
         7'h0F:   decode = 6'b11_1000;
         default: decode = 6'b00_0000;
      endcase
   endfunction

   // Registered decoder: captures the D-stage instruction when not stalled.
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dec_inst_type  <= 4'd0;
         dec_fence      <= 1'b0;
         dec_n_bad_inst <= 1'b1;
      end else if (dec_n_stall) begin
         dec_n_bad_inst <= decode(dec_instruction)[5];
         dec_fence      <= decode(dec_instruction)[4];
         dec_inst_type  <= decode(dec_instruction)[3:0];
      end
   end

   // Scoreboard: expected issue order is the accepted order of legal fetches.
   always @(negedge clk) begin
      if (!n_rst) begin
         sb.delete();
      end else begin
         if (issue_valid && ex_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_issue: issued pc=%h but nothing expected", issue_pc);
            end else begin
               logic [31:0] exp_pc;
               exp_pc = sb.pop_front();
               if (issue_pc !== exp_pc) begin
                  failures++;
                  $display("FAIL sb_issue: issue_pc=%h expected=%h", issue_pc, exp_pc);
               end
            end
         end
         if (flush) sb.delete();
         if (f_valid && f_ready && decode(f_inst)[5]) sb.push_back(f_pc);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time=%0t expected=<100000", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic fv, input logic [31:0] inst, input logic [31:0] pc,
                      input logic exr, input logic md, input logic fl);
      f_valid  = fv;
      f_inst   = inst;
      f_pc     = pc;
      ex_ready = exr;
      mem_done = md;
      flush    = fl;
   endtask

   typedef struct {
      logic        fv;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        exr;
      logic        md;
      logic        e_f_ready;
      logic        e_n_stall;
      logic        e_iv;
      logic [31:0] e_ipc;
      logic [2:0]  e_cnt;
   } vec_t;

   function automatic vec_t mkv(input logic fv, input logic [31:0] pc, input logic exr,
                                input logic md, input logic frdy, input logic nst,
                                input logic iv, input logic [31:0] ipc);
      vec_t v;
      v.fv = fv; v.inst = fv ? ADDI : 32'h0; v.pc = pc; v.exr = exr; v.md = md;
      v.e_f_ready = frdy; v.e_n_stall = nst; v.e_iv = iv; v.e_ipc = ipc; v.e_cnt = 3'd0;
      return v;
   endfunction

   vec_t vecs[14];

   initial begin
      // Streaming ADDI with a three-cycle execute stall and a stray mem_done at zero.
      vecs[0]  = mkv(1, 32'h00, 1, 0, 1, 1, 0, 32'h00);
      vecs[1]  = mkv(1, 32'h04, 1, 0, 1, 1, 0, 32'h00);
      vecs[2]  = mkv(1, 32'h08, 1, 0, 1, 1, 1, 32'h00);
      vecs[3]  = mkv(1, 32'h0C, 1, 1, 1, 1, 1, 32'h04);
      vecs[4]  = mkv(1, 32'h10, 1, 0, 1, 1, 1, 32'h08);
      vecs[5]  = mkv(1, 32'h14, 0, 0, 0, 0, 1, 32'h0C);
      vecs[6]  = mkv(1, 32'h14, 0, 0, 0, 0, 1, 32'h0C);
      vecs[7]  = mkv(1, 32'h14, 0, 0, 0, 0, 1, 32'h0C);
      vecs[8]  = mkv(1, 32'h14, 1, 0, 1, 1, 1, 32'h0C);
      vecs[9]  = mkv(1, 32'h18, 1, 0, 1, 1, 1, 32'h10);
      vecs[10] = mkv(1, 32'h1C, 1, 0, 1, 1, 1, 32'h14);
      vecs[11] = mkv(0, 32'h00, 1, 0, 1, 1, 1, 32'h18);
      vecs[12] = mkv(0, 32'h00, 1, 0, 1, 1, 1, 32'h1C);
      vecs[13] = mkv(0, 32'h00, 1, 0, 1, 1, 0, 32'h00);

      // Reset
      drv(0, 32'h0, 32'h0, 0, 0, 0);
      n_rst = 1'b1;
      #1 n_rst = 1'b0;
      #1;
      chk("rst_f_ready",     32'(f_ready),     32'd1);
      chk("rst_dec_n_irdy",  32'(dec_n_irdy),  32'd1);
      chk("rst_dec_n_stall", 32'(dec_n_stall), 32'd1);
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_trap",        32'(trap),        32'd0);
      chk("rst_fence_busy",  32'(fence_busy),  32'd0);
      chk("rst_mem_cnt",     32'(mem_cnt),     32'd0);
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;

      // Table-driven streaming / backpressure
      for (int i = 0; i < 14; i++) begin
         drv(vecs[i].fv, vecs[i].inst, vecs[i].pc, vecs[i].exr, vecs[i].md, 1'b0);
         #1;
         chk($sformatf("vec%0d_f_ready", i),     32'(f_ready),     32'(vecs[i].e_f_ready));
         chk($sformatf("vec%0d_dec_n_stall", i), 32'(dec_n_stall), 32'(vecs[i].e_n_stall));
         chk($sformatf("vec%0d_issue_valid", i), 32'(issue_valid), 32'(vecs[i].e_iv));
         if (vecs[i].e_iv) chk($sformatf("vec%0d_issue_pc", i), issue_pc, vecs[i].e_ipc);
         chk($sformatf("vec%0d_mem_cnt", i),     32'(mem_cnt),     32'(vecs[i].e_cnt));
         tick();
      end

      // Fence drain
      drv(1, LW,    32'h100, 1, 0, 0); tick();
      drv(1, LW,    32'h104, 1, 0, 0); tick();
      drv(1, FENCE, 32'h108, 1, 0, 0); tick();
      drv(0, 32'h0, 32'h0,   1, 0, 0); tick();
      #1;
      chk("fence_held",       32'(issue_valid), 32'd0);
      chk("fence_cnt2",       32'(mem_cnt),     32'd2);
      chk("fence_busy_early", 32'(fence_busy),  32'd0);
      tick();
      drv(0, 32'h0, 32'h0, 1, 1, 0); #1;
      chk("fence_busy", 32'(fence_busy), 32'd1);
      tick();
      drv(0, 32'h0, 32'h0, 1, 0, 0); #1;
      chk("fence_cnt1",      32'(mem_cnt),     32'd1);
      chk("fence_busy_hold", 32'(fence_busy),  32'd1);
      chk("fence_held2",     32'(issue_valid), 32'd0);
      tick();
      drv(0, 32'h0, 32'h0, 1, 1, 0); tick();
      drv(0, 32'h0, 32'h0, 1, 0, 0); #1;
      chk("fence_cnt0",     32'(mem_cnt),     32'd0);
      chk("fence_busy_off", 32'(fence_busy),  32'd0);
      chk("fence_issue",    32'(issue_valid), 32'd1);
      chk("fence_issue_pc", issue_pc,         32'h108);
      tick();
      #1 chk("fence_gone", 32'(issue_valid), 32'd0);

      // Counter saturation
      for (int k = 0; k < 8; k++) begin
         drv(1, LW, 32'h200 + 32'(4 * k), 1, 0, 0);
         tick();
      end
      drv(0, 32'h0, 32'h0, 1, 0, 0); tick();
      #1;
      chk("sat_cnt7", 32'(mem_cnt),     32'd7);
      chk("sat_hold", 32'(issue_valid), 32'd0);
      tick();
      #1;
      chk("sat_hold2",   32'(issue_valid), 32'd0);
      chk("sat_f_ready", 32'(f_ready),     32'd1);
      tick();
      drv(0, 32'h0, 32'h0, 1, 1, 0); tick();
      drv(0, 32'h0, 32'h0, 1, 0, 0); #1;
      chk("sat_cnt6",    32'(mem_cnt),     32'd6);
      chk("sat_release", 32'(issue_valid), 32'd1);
      chk("sat_pc",      issue_pc,         32'h21C);
      tick();
      #1;
      chk("sat_refill", 32'(mem_cnt),     32'd7);
      chk("sat_empty",  32'(issue_valid), 32'd0);
      drv(1, LW, 32'h220, 1, 1, 0); tick();
      drv(0, 32'h0, 32'h0, 1, 0, 0); tick();
      drv(0, 32'h0, 32'h0, 1, 1, 0); #1;
      chk("incdec_issue", 32'(issue_valid), 32'd1);
      tick();
      drv(0, 32'h0, 32'h0, 1, 0, 0); #1;
      chk("incdec_same", 32'(mem_cnt), 32'd6);
      for (int k = 0; k < 6; k++) begin
         drv(0, 32'h0, 32'h0, 1, 1, 0);
         tick();
      end
      drv(0, 32'h0, 32'h0, 1, 0, 0); #1;
      chk("drain_cnt0", 32'(mem_cnt), 32'd0);
      tick();

      // Trap and flush
      drv(1, BAD,  32'h40, 1, 0, 0); tick();
      drv(1, ADDI, 32'h44, 1, 0, 0); tick();
      drv(1, ADDI, 32'h48, 1, 0, 0); #1;
      chk("bad_not_issued", 32'(issue_valid), 32'd0);
      chk("bad_f_ready",    32'(f_ready),     32'd0);
      tick();
      #1;
      chk("trap_set",     32'(trap),        32'd1);
      chk("trap_pc",      trap_pc,          32'h40);
      chk("trap_noissue", 32'(issue_valid), 32'd0);
      chk("trap_frozen",  32'(dec_n_stall), 32'd0);
      chk("trap_f_ready", 32'(f_ready),     32'd0);
      tick();
      drv(1, ADDI, 32'h48, 1, 0, 1); #1;
      chk("trap_until_flush", 32'(trap),    32'd1);
      chk("flush_f_ready",    32'(f_ready), 32'd0);
      tick();
      drv(0, 32'h0, 32'h0, 1, 0, 0); #1;
      chk("flush_trap_clr", 32'(trap),        32'd0);
      chk("flush_f_ready1", 32'(f_ready),     32'd1);
      chk("flush_d_empty",  32'(dec_n_irdy),  32'd1);
      chk("flush_i_empty",  32'(issue_valid), 32'd0);
      tick();
      #1;
      chk("flush_still_empty", 32'(issue_valid), 32'd0);
      chk("sb_empty",          32'(sb.size()),   32'd0);

      // Asynchronous reset mid-drain
      drv(1, LW,    32'h300, 1, 0, 0); tick();
      drv(1, LW,    32'h304, 1, 0, 0); tick();
      drv(1, LW,    32'h308, 1, 0, 0); tick();
      drv(1, FENCE, 32'h30C, 1, 0, 0); tick();
      drv(0, 32'h0, 32'h0,   1, 0, 0); tick();
      tick();
      #1;
      chk("pre_rst_busy", 32'(fence_busy), 32'd1);
      chk("pre_rst_cnt",  32'(mem_cnt),    32'd3);
      #1 n_rst = 1'b0;
      #1;
      chk("arst_f_ready",     32'(f_ready),     32'd1);
      chk("arst_dec_n_irdy",  32'(dec_n_irdy),  32'd1);
      chk("arst_dec_n_stall", 32'(dec_n_stall), 32'd1);
      chk("arst_issue_valid", 32'(issue_valid), 32'd0);
      chk("arst_trap",        32'(trap),        32'd0);
      chk("arst_fence_busy",  32'(fence_busy),  32'd0);
      chk("arst_trap_pc",     trap_pc,          32'h0);
      chk("arst_issue_pc",    issue_pc,         32'h0);
      chk("arst_dec_inst",    dec_instruction,  32'h0);
      chk("arst_mem_cnt",     32'(mem_cnt),     32'd0);
      tick();
      n_rst = 1'b1;
      tick();
      #1;
      chk("post_rst_busy",   32'(fence_busy),  32'd0);
      chk("post_rst_iv",     32'(issue_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
